// File: rtl/csr_pmu_pkg.sv
// Shared constants and helpers for the counter/PMU CSR bank.
package csr_pmu_pkg;

  // Counter-range CSR bases
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_M = 2'd3;

  // New CSR value for a read-modify-write op; a plain read leaves it unchanged.
  function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                               input logic [31:0] old,
                                               input logic [31:0] operand);
    logic [31:0] res;
    case (csr_op_e'(op))
      CSR_OP_RW: res = operand;
      CSR_OP_RS: res = old | operand;
      CSR_OP_RC: res = old & ~operand;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_pmu_counters_cnt.sv
// One free-running counter with inhibit, 32-bit half writes and a wrap pulse.
module pmu_counter #(
  parameter int CNT_W = 64,
  parameter int INC_W = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             inhibit,
  input  logic [INC_W-1:0] inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wr_data,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W:0] sum;

  // Carry out of the top bit marks a wrap from all-ones; a SW write suppresses it.
  assign sum = {1'b0, cnt} + SUM_W'(inc);
  assign ovf = !inhibit && !(wr_lo || wr_hi) && sum[CNT_W];

  // SW write of either half holds the whole counter for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) cnt[31:0]       <= wr_data;
      if (wr_hi) cnt[CNT_W-1:32] <= wr_data[CNT_W-33:0];
    end else if (!inhibit) begin
      cnt <= sum[CNT_W-1:0];
    end
  end
endmodule

// File: rtl/csr_pmu_counters.sv
// Machine counter / HPM CSR bank: decode, privilege checks, read mux,
// event selectors with sticky overflow, and the overflow interrupt.
module csr_pmu_counters
  import csr_pmu_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8,
  parameter int CNT_W      = 64,
  parameter int RETIRE_W   = 2
)(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            csr_valid_i,
  input  logic [11:0]                     csr_addr_i,
  input  logic [1:0]                      csr_op_i,
  input  logic                            csr_wr_i,
  input  logic [31:0]                     csr_operand_i,
  input  logic [1:0]                      priv_i,
  input  logic [$clog2(RETIRE_W+1)-1:0]   retire_cnt_i,
  input  logic [NUM_EVENTS-1:0]           event_i,
  output logic                            csr_hit_o,
  output logic [31:0]                     csr_rd_data_o,
  output logic                            csr_fault_o,
  output logic                            pmu_irq_o
);
  localparam int NUM_CNT = NUM_HPM + 3;          // index 1 is a hole
  localparam int HPM_N   = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int SEL_W   = $clog2(NUM_EVENTS + 1);
  localparam int RC_W    = $clog2(RETIRE_W + 1);
  localparam logic [4:0]         LAST_IDX = 5'(NUM_HPM + 2);
  localparam logic [NUM_CNT-1:0] CNT_MASK = ~(NUM_CNT'(2));

  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
  logic [NUM_CNT-1:0]            cnt_ovf;
  logic [NUM_CNT-1:0]            inhibit;
  logic [NUM_CNT-1:0]            counteren;
  logic [HPM_N-1:0]              of;
  logic [HPM_N-1:0][SEL_W-1:0]   sel;
  logic [HPM_N-1:0]              hpm_evt;
  logic [HPM_N-1:0]              hpm_ovf;
  logic [HPM_N-1:0]              evt_wr;
  logic [NUM_EVENTS:0]           ev_ext;

  logic [4:0]  idx;
  logic        idx_hpm, idx_cnt;
  logic        m_lo, m_hi, u_lo, u_hi, sel_hi;
  logic        is_mcnt, is_ucnt, is_inh, is_en, is_evt;
  logic [31:0] cen_ext;
  logic [CNT_W-1:0] cnt_sel;
  logic [63:0] cnt_ext;
  logic [31:0] evt_rd;
  logic [31:0] rd_data;
  logic [31:0] wr_val;
  logic        wr_en;
  logic [SEL_W-1:0] sel_legal;
  logic        unused_ovf;

  // Address decode
  assign idx     = csr_addr_i[4:0];
  assign idx_hpm = (idx >= 5'd3) && (idx <= LAST_IDX);
  assign idx_cnt = (idx == 5'd0) || (idx == 5'd2) || idx_hpm;
  assign m_lo    = csr_addr_i[11:5] == CSR_MCYCLE[11:5];
  assign m_hi    = csr_addr_i[11:5] == CSR_MCYCLEH[11:5];
  assign u_lo    = csr_addr_i[11:5] == CSR_CYCLE[11:5];
  assign u_hi    = csr_addr_i[11:5] == CSR_CYCLEH[11:5];
  assign sel_hi  = m_hi || u_hi;
  assign is_mcnt = (m_lo || m_hi) && idx_cnt;
  assign is_ucnt = (u_lo || u_hi) && idx_cnt;
  assign is_inh  = csr_addr_i == CSR_MCOUNTINHIBIT;
  assign is_en   = csr_addr_i == CSR_MCOUNTEREN;
  assign is_evt  = (csr_addr_i[11:5] == CSR_MHPMEVENT3[11:5]) && idx_hpm;

  assign csr_hit_o = is_mcnt || is_ucnt || is_inh || is_en || is_evt;

  // U-mode sees a shadow only when its mcounteren bit is set; shadows are never writable.
  assign cen_ext     = 32'(counteren);
  assign csr_fault_o = csr_valid_i && csr_hit_o &&
                       ((is_ucnt && csr_wr_i) ||
                        (!is_ucnt && (priv_i < PRIV_M)) ||
                        (is_ucnt && (priv_i < PRIV_M) && !cen_ext[idx]));

  // Select the addressed counter and event register
  always_comb begin
    cnt_sel = '0;
    evt_rd  = '0;
    for (int g = 0; g < NUM_CNT; g++)
      if (idx == 5'(g)) cnt_sel = cnt[g];
    for (int i = 0; i < NUM_HPM; i++)
      if (idx == 5'(i + 3)) evt_rd = {of[i], 31'(sel[i])};
  end

  assign cnt_ext = 64'(cnt_sel);

  // Read mux returns the pre-write value
  always_comb begin
    rd_data = '0;
    if (is_mcnt || is_ucnt) rd_data = sel_hi ? cnt_ext[63:32] : cnt_ext[31:0];
    else if (is_inh)        rd_data = 32'(inhibit);
    else if (is_en)         rd_data = 32'(counteren);
    else if (is_evt)        rd_data = evt_rd;
  end

  assign csr_rd_data_o = rd_data;
  assign wr_val        = csr_apply_op(csr_op_i, rd_data, csr_operand_i);
  assign wr_en         = csr_valid_i && csr_hit_o && csr_wr_i && !csr_fault_o;
  assign sel_legal     = (wr_val[SEL_W-1:0] > SEL_W'(NUM_EVENTS)) ? '0 : wr_val[SEL_W-1:0];

  // Bit 0 of ev_ext is the "no event" slot for selector 0
  assign ev_ext = {event_i, 1'b0};

  // mcountinhibit / mcounteren with the hole and unimplemented bits forced to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit   <= '0;
      counteren <= '0;
    end else if (wr_en) begin
      if (is_inh) inhibit   <= wr_val[NUM_CNT-1:0] & CNT_MASK;
      if (is_en)  counteren <= wr_val[NUM_CNT-1:0] & CNT_MASK;
    end
  end

  // Per-HPM event decode and write strobes
  for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
    assign hpm_evt[i] = ev_ext[sel[i]];
    assign hpm_ovf[i] = cnt_ovf[i+3];
    assign evt_wr[i]  = wr_en && is_evt && (idx == 5'(i + 3));
  end

  // mhpmevent: hardware overflow set beats a same-cycle SW write of OF
  always_ff @(posedge clk) begin
    if (rst) begin
      of  <= '0;
      sel <= '0;
    end else begin
      for (int i = 0; i < NUM_HPM; i++) begin
        if (hpm_ovf[i])     of[i] <= 1'b1;
        else if (evt_wr[i]) of[i] <= wr_val[31];
        if (evt_wr[i])      sel[i] <= sel_legal;
      end
    end
  end

  // Overflow interrupt follows the OF bits by one cycle
  always_ff @(posedge clk) begin
    if (rst) pmu_irq_o <= 1'b0;
    else     pmu_irq_o <= |of;
  end

  // Counter array: mcycle, (hole), minstret, mhpmcounter3..
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    if (g == 1) begin : g_gap
      assign cnt[g]     = '0;
      assign cnt_ovf[g] = 1'b0;
    end else if (g == 0) begin : g_cycle
      pmu_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt (
        .clk(clk), .rst(rst), .inhibit(inhibit[g]), .inc(1'b1),
        .wr_lo(wr_en && is_mcnt && !sel_hi && (idx == 5'(g))),
        .wr_hi(wr_en && is_mcnt &&  sel_hi && (idx == 5'(g))),
        .wr_data(wr_val), .cnt(cnt[g]), .ovf(cnt_ovf[g]));
    end else if (g == 2) begin : g_instret
      pmu_counter #(.CNT_W(CNT_W), .INC_W(RC_W)) u_cnt (
        .clk(clk), .rst(rst), .inhibit(inhibit[g]), .inc(retire_cnt_i),
        .wr_lo(wr_en && is_mcnt && !sel_hi && (idx == 5'(g))),
        .wr_hi(wr_en && is_mcnt &&  sel_hi && (idx == 5'(g))),
        .wr_data(wr_val), .cnt(cnt[g]), .ovf(cnt_ovf[g]));
    end else begin : g_hpmc
      pmu_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt (
        .clk(clk), .rst(rst), .inhibit(inhibit[g]), .inc(hpm_evt[g-3]),
        .wr_lo(wr_en && is_mcnt && !sel_hi && (idx == 5'(g))),
        .wr_hi(wr_en && is_mcnt &&  sel_hi && (idx == 5'(g))),
        .wr_data(wr_val), .cnt(cnt[g]), .ovf(cnt_ovf[g]));
    end
  end

  // mcycle/minstret wrap silently
  assign unused_ovf = ^cnt_ovf[2:0];

endmodule
